// File: rtl/mux16_arbiter_pkg.sv
// Shared definitions for the mux16 round-robin arbiter: sizes, FSM state
// encoding and the one-hot decode used to build the grant vector.
package mux16_arbiter_pkg;

  // Number of requesters sharing the mux16 datapath, and the select width.
  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  // Arbiter FSM: IDLE waits for any request, GRANT owns the datapath.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Decode a 4-bit requester index into a 16-bit one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    return 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/mux16_arbiter_rr_pick16.sv
// Rotating-priority picker: returns the first set request at index ptr,
// ptr+1, ... wrapping modulo 16. Purely combinational.
module rr_pick16
  import mux16_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    logic [SEL_W-1:0] cand;
    found_o = 1'b0;
    idx_o   = ptr_i;
    cand    = ptr_i;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr_i + SEL_W'(k);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end else begin
        found_o = found_o;
        idx_o   = idx_o;
      end
    end
  end

endmodule

// File: rtl/mux16_arbiter.sv
// Round-robin arbiter/sequencer for a shared mux16 datapath. Selects one of
// 16 requesters, drives the mux select and a one-hot grant, and presents a
// valid/ready beat handshake downstream with a bounded burst per grant.
module mux16_arbiter
  import mux16_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_last,
  input  logic             out_ready,
  output logic [SEL_W-1:0] control,
  output logic [N_REQ-1:0] grant,
  output logic             out_valid,
  output logic             beat_done
);

  // Beat count at which the grant is forcibly rotated to the next requester.
  localparam logic [SEL_W-1:0] BURST_LAST = SEL_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [SEL_W-1:0] control_q, control_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             out_valid_q, out_valid_d;

  logic             xfer_s;
  logic             release_s;
  logic [SEL_W-1:0] pick_ptr_s;
  logic             found_s;
  logic [SEL_W-1:0] pick_idx_s;

  // Decide whether the current owner gives up the datapath this cycle and
  // which pointer the picker must rotate from.
  always_comb begin
    xfer_s    = out_valid_q & out_ready;
    release_s = 1'b0;
    if (state_q == GRANT) begin
      if (xfer_s) begin
        // A beat moves: release on last beat, full burst, or dropped request.
        release_s = req_last[control_q] | (beat_cnt_q == BURST_LAST) | ~req[control_q];
      end else begin
        // No beat: the owner withdrawing its request aborts the grant.
        release_s = ~req[control_q];
      end
    end else begin
      release_s = 1'b0;
    end
    // On release the just-served requester drops to lowest priority.
    if (release_s) begin
      pick_ptr_s = control_q + 4'd1;
    end else begin
      pick_ptr_s = ptr_q;
    end
  end

  rr_pick16 u_pick (
    .req_i   (req),
    .ptr_i   (pick_ptr_s),
    .found_o (found_s),
    .idx_o   (pick_idx_s)
  );

  // Next-state logic for the FSM, rotation pointer, beat counter and outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    beat_cnt_d  = beat_cnt_q;
    control_d   = control_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d     = GRANT;
          control_d   = pick_idx_s;
          grant_d     = onehot4(pick_idx_s);
          out_valid_d = 1'b1;
          beat_cnt_d  = 4'd0;
        end else begin
          // control holds so the mux output stays stable while idle.
          grant_d     = 16'h0000;
          out_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          ptr_d = pick_ptr_s;
          if (found_s) begin
            // Back-to-back hand-over with no bubble cycle.
            control_d   = pick_idx_s;
            grant_d     = onehot4(pick_idx_s);
            out_valid_d = 1'b1;
            beat_cnt_d  = 4'd0;
          end else begin
            state_d     = IDLE;
            grant_d     = 16'h0000;
            out_valid_d = 1'b0;
          end
        end else if (xfer_s) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d     = IDLE;
        grant_d     = 16'h0000;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // FSM and registered outputs; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 4'd0;
      beat_cnt_q  <= 4'd0;
      control_q   <= 4'd0;
      grant_q     <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      control_q   <= control_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign control   = control_q;
  assign grant     = grant_q;
  assign out_valid = out_valid_q;
  assign beat_done = out_valid_q & out_ready;

endmodule
